// File: rtl/sync_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sync_pkg
//  Brief    : Shared encodings and default timing for the sync link
//             (sync_tx transmitter and fsm_sync receiver).
//  Revision : 1.0  initial release
// ============================================================================
package sync_pkg;

  // Transmitter state encoding, visible on the tx_state port
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_GUARD = 3'd2,
    ST_DATA  = 3'd3,
    ST_WAIT  = 3'd4
  } tx_state_e;

  // Default timing at a 10 MHz system clock
  localparam int CLK_HZ     = 10_000_000;
  localparam int PULSE_CYC  = 1;      // 100 ns sync pulse
  localparam int BIT_CYC    = 10;     // 1 us guard / OOK bit
  localparam int PERIOD_CYC = 10_000; // 1 ms frame period

endpackage : sync_pkg
`default_nettype wire

// File: rtl/sync_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module   : sync_bit_timer
//  Brief    : Loadable down-counter with terminal-count flag. Stops at zero
//             and only restarts through an explicit load.
//  Revision : 1.0  initial release
// ============================================================================
module sync_bit_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,       // asynchronous, active low
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load has priority; otherwise count down and park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule : sync_bit_timer
`default_nettype wire

// File: rtl/sync_tx.sv
`default_nettype none
// ============================================================================
//  Module   : sync_tx
//  Brief    : Periodic RF sync pulse generator with an optional OOK payload
//             byte (MSB first) after each sync, one-entry payload buffer.
//  Revision : 1.0  initial release
// ============================================================================
module sync_tx #(
  parameter int PULSE_CYC  = sync_pkg::PULSE_CYC,
  parameter int BIT_CYC    = sync_pkg::BIT_CYC,
  parameter int PERIOD_CYC = sync_pkg::PERIOD_CYC,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,        // asynchronous, active low
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              rfout,
  output logic [2:0]        tx_state,
  output logic              frame_done
);

  import sync_pkg::*;

  localparam int TMAX = (PULSE_CYC > BIT_CYC) ? PULSE_CYC : BIT_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PW   = $clog2(PERIOD_CYC);
  localparam int BW   = $clog2(DATA_W + 1);

  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] BIT_LD   = TW'(BIT_CYC - 1);
  localparam logic [PW-1:0] PCNT_END = PW'(PERIOD_CYC - 1);
  localparam logic [BW-1:0] BITS_LD  = BW'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic [BW-1:0]     bits_q, bits_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic              rfout_q, rfout_d;
  logic              frame_done_q, frame_done_d;
  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tmr_tc;

  // Shared timer for the sync pulse, guard and each payload bit
  sync_bit_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // Next-state, buffer, period counter and registered-output decode
  always_comb begin
    state_d    = state_q;
    bits_d     = bits_q;
    shreg_d    = shreg_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    // The buffer accepts in any state; it can never be both filled and
    // consumed on one edge because consuming requires it to be full.
    if (data_valid && !buf_full_q) begin
      buf_d      = data_in;
      buf_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d  = ST_SYNC;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
        end
      end
      ST_SYNC: begin
        if (tmr_tc) begin
          state_d  = ST_GUARD;
          tmr_load = 1'b1;
          tmr_val  = BIT_LD;
        end
      end
      ST_GUARD: begin
        if (tmr_tc) begin
          if (buf_full_q) begin
            state_d    = ST_DATA;
            tmr_load   = 1'b1;
            tmr_val    = BIT_LD;
            shreg_d    = buf_q;
            bits_d     = BITS_LD;
            buf_full_d = 1'b0;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_DATA: begin
        if (tmr_tc) begin
          if (bits_q == '0) begin
            state_d = ST_WAIT;
          end else begin
            bits_d   = bits_q - BW'(1);
            shreg_d  = shreg_q << 1;
            tmr_load = 1'b1;
            tmr_val  = BIT_LD;
          end
        end
      end
      ST_WAIT: begin
        if (pcnt_q == PCNT_END) begin
          if (en) begin
            state_d  = ST_SYNC;
            tmr_load = 1'b1;
            tmr_val  = PULSE_LD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Period counter restarts at each sync entry, holds while idle and
    // never runs past the end of the period.
    pcnt_d = pcnt_q;
    if (state_d == ST_SYNC && state_q != ST_SYNC) begin
      pcnt_d = '0;
    end else if (state_q != ST_IDLE && pcnt_q != PCNT_END) begin
      pcnt_d = pcnt_q + PW'(1);
    end

    // Outputs are decoded from next-state values so they line up with tx_state
    rfout_d      = (state_d == ST_SYNC) ||
                   (state_d == ST_DATA && shreg_d[DATA_W-1]);
    frame_done_d = (state_d == ST_WAIT) && (pcnt_d == PCNT_END);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      pcnt_q       <= '0;
      bits_q       <= '0;
      shreg_q      <= '0;
      buf_q        <= '0;
      buf_full_q   <= 1'b0;
      rfout_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      bits_q       <= bits_d;
      shreg_q      <= shreg_d;
      buf_q        <= buf_d;
      buf_full_q   <= buf_full_d;
      rfout_q      <= rfout_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_state   = state_q;
  assign rfout      = rfout_q;
  assign frame_done = frame_done_q;
  assign data_ready = ~buf_full_q;

endmodule : sync_tx
`default_nettype wire
